spi_slave_regs: RTL and testbench
=================================

SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

Interface
REQ-001 SHALL have parameter: ADDR_W, default 3, register address width; register count NREG = 2^ADDR_W.
REQ-002 SHALL have port: sclk  input  1  SPI clock; all logic on rising edge only.
REQ-003 SHALL have port: rst  input  1  reset, synchronous to sclk, active-low.
REQ-004 SHALL have port: ss  input  1  slave select, active-low.
REQ-005 SHALL have port: mosi  input  1  serial data from master.
REQ-006 SHALL have port: miso  output  1  serial data to master; high-impedance whenever ss=1 (combinational).
REQ-007 SHALL have port: status_in  input  8  value returned on reads of address NREG-1.
REQ-008 SHALL have port: wr_en  output  1  one-cycle write strobe.
REQ-009 SHALL have port: wr_addr  output  ADDR_W  address of last completed write.
REQ-010 SHALL have port: wr_data  output  8  data of last completed write.
REQ-011 SHALL have port: frame_err  output  1  sticky aborted-frame flag.

Function
REQ-012 SHALL frame bytes as 8 sclk rising edges sampled with ss=0, counted by a 3-bit bit_cnt 0..7 that wraps 7->0.
REQ-013 SHALL shift bytes LSB-first: mosi sampled at edge with bit_cnt=k is bit k.
REQ-014 SHALL implement FSM states CMD, WDATA, RDATA; state and bit_cnt change only on rising edges with ss=0, except REQ-021.
REQ-015 SHALL decode the first byte of a frame as command: bit7=1 read, bit7=0 write; bits[ADDR_W-1:0] address; remaining bits ignored.
REQ-016 SHALL transition at the edge completing the command byte: CMD->RDATA if read, CMD->WDATA if write; latch address into addr.
REQ-017 SHALL, in WDATA at edge completing a byte: write reg[addr] unless addr=NREG-1 (ignored, read-only); set wr_addr=addr, wr_data=byte, wr_en=1 for exactly the next sclk cycle; increment addr modulo NREG; remain in WDATA (burst).
REQ-018 SHALL, in RDATA, load an 8-bit shadow at the edge completing the previous byte from reg[addr] (or status_in if addr=NREG-1); after each byte completes, increment addr modulo NREG and reload shadow; remain in RDATA (burst).
REQ-019 SHALL register miso: after the edge completing a byte with next state RDATA, miso=shadow[0] of the new shadow; after edge with bit_cnt=k<7 in RDATA, miso=shadow[k+1]; at all other times miso=0 while ss=0.
REQ-020 SHALL give read data a register-to-miso snapshot semantics: a write to reg[addr] or status_in change mid-byte does not alter bits already loaded in shadow.
REQ-021 SHALL, on any rising edge sampled with ss=1: state->CMD, bit_cnt->0, wr_en->0; registers and wr_addr/wr_data unchanged.
REQ-022 SHALL set frame_err=1 on a rising edge with ss=1 when bit_cnt != 0 (partial byte); frame_err cleared only by reset.
REQ-023 SHALL discard partial bytes: no register write, no wr_en.
REQ-024 SHALL let reset take priority over ss and all transfers, aborting a frame mid-byte without setting frame_err.

Reset
REQ-025 SHALL, on rising edge with rst=0: state=CMD, bit_cnt=0, addr=0, all registers=0x00, shadow=0x00, miso (ss=0)=0, wr_en=0, wr_addr=0, wr_data=0x00, frame_err=0.
REQ-026 SHALL require only one reset edge; first frame accepted on the next edge with rst=1, ss=0.

Verification
REQ-027 SHALL pass: write frame cmd=0x02, data=0xA5 -> wr_en one cycle after 16th edge, wr_addr=2, wr_data=0xA5; subsequent read cmd=0x82 returns 0xA5 on miso LSB-first.
REQ-028 SHALL pass: burst write cmd=0x06, data 0x11,0x22 -> reg6=0x11, second write to addr 7 ignored (wr_en still pulses, wr_addr=7); burst read cmd=0x86 returns 0x11 then status_in.
REQ-029 SHALL pass: burst read cmd=0x87 with status_in=0x5C -> bytes 0x5C, reg0, reg1 (address wrap 7->0).
REQ-030 SHALL pass: ss deasserted after 3 bits of a data byte -> no write, frame_err=1, next full frame decodes normally.
REQ-031 SHALL pass: rst=0 mid read byte -> all REQ-025 values next cycle, frame_err=0, registers cleared.
REQ-032 SHALL pass: ss=1 -> miso high-impedance; ss=0 in CMD -> miso=0.

Source files
------------

// File: rtl/spi_slave_regs_if.sv
// SPI bus between master and register slave. ss is active-low; miso is
// high-impedance while the slave is not selected.
interface spi_slave_regs_if;
  logic ss;
  logic mosi;
  logic miso;

  modport master (output ss, output mosi, input miso);
  modport slave  (input ss, input mosi, output miso);
endinterface

// File: rtl/spi_slave_regs.sv
// SPI slave with a small byte-wide register file. The first byte of a frame is
// a command (bit7=read, low bits=address); the following bytes are a burst of
// writes or reads with the address auto-incrementing modulo NREG. The top
// address is read-only and returns status_in. Bytes travel LSB first.
module spi_slave_regs #(
  parameter int ADDR_W = 3
) (
  input  logic              sclk,
  input  logic              rst,
  spi_slave_regs_if.slave   bus,
  input  logic [7:0]        status_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_err
);
  localparam int NREG = 1 << ADDR_W;

  localparam logic [1:0] CMD   = 2'd0;
  localparam logic [1:0] WDATA = 2'd1;
  localparam logic [1:0] RDATA = 2'd2;

  logic [1:0]        state;
  logic [2:0]        bit_cnt;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        regs [NREG];
  logic [6:0]        sh;
  logic [7:0]        shadow;
  logic              miso_q;

  logic              byte_done;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] nxt_addr;
  logic [7:0]        rd_cmd;
  logic [7:0]        rd_nxt;
  logic [2:0]        nxt_bit;

  // Byte in flight completes on this edge: the current mosi is its MSB.
  assign byte_done = (bit_cnt == 3'd7);
  assign rx_byte   = {bus.mosi, sh};
  assign cmd_addr  = rx_byte[ADDR_W-1:0];
  assign nxt_addr  = addr + 1'b1;
  assign nxt_bit   = bit_cnt + 3'd1;

  // Read sources for the two shadow-load points: the address just decoded
  // from a command, and the next address of a read burst.
  assign rd_cmd = (cmd_addr == '1) ? status_in : regs[cmd_addr];
  assign rd_nxt = (nxt_addr == '1) ? status_in : regs[nxt_addr];

  // miso floats when not selected; otherwise it is the registered bit.
  assign bus.miso = bus.ss ? 1'bz : miso_q;

  // Frame sequencing, register file, shadow loads and registered miso.
  always_ff @(posedge sclk) begin
    if (!rst) begin
      state     <= CMD;
      bit_cnt   <= '0;
      addr      <= '0;
      sh        <= '0;
      shadow    <= '0;
      miso_q    <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.ss) begin
      // Deselect aborts the frame; a partial byte is dropped and flagged.
      state   <= CMD;
      bit_cnt <= '0;
      wr_en   <= 1'b0;
      miso_q  <= 1'b0;
      if (bit_cnt != 3'd0) frame_err <= 1'b1;
    end else begin
      wr_en   <= 1'b0;
      miso_q  <= 1'b0;
      bit_cnt <= nxt_bit;
      sh      <= {bus.mosi, sh[6:1]};
      case (state)
        CMD: begin
          if (byte_done) begin
            addr <= cmd_addr;
            if (rx_byte[7]) begin
              state  <= RDATA;
              shadow <= rd_cmd;
              miso_q <= rd_cmd[0];
            end else begin
              state <= WDATA;
            end
          end
        end
        WDATA: begin
          if (byte_done) begin
            if (addr != '1) regs[addr] <= rx_byte;
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= rx_byte;
            addr    <= nxt_addr;
          end
        end
        RDATA: begin
          // Shadow is a snapshot taken at the byte boundary, so later
          // changes to the source do not disturb the byte on the wire.
          if (byte_done) begin
            addr   <= nxt_addr;
            shadow <= rd_nxt;
            miso_q <= rd_nxt[0];
          end else begin
            miso_q <= shadow[nxt_bit];
          end
        end
        default: state <= CMD;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave_regs.sv
// Randomized bench for spi_slave_regs against a byte-level register model.
module tb_spi_slave_regs;
  localparam int ADDR_W = 3;
  localparam int NREG   = 1 << ADDR_W;

  logic              sclk = 1'b0;
  logic              rst  = 1'b0;
  logic [7:0]        status_in = 8'h00;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              frame_err;

  spi_slave_regs_if bus();

  spi_slave_regs #(.ADDR_W(ADDR_W)) dut (
    .sclk      (sclk),
    .rst       (rst),
    .bus       (bus),
    .status_in (status_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err)
  );

  always #5 sclk = ~sclk;

  int                n_chk = 0;
  int                n_err = 0;
  logic [7:0]        mdl [NREG];
  logic              pend = 1'b0;
  logic [ADDR_W-1:0] pend_addr;
  logic [7:0]        pend_data;
  logic              exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Strobe expected in the cycle after a completed write byte, idle otherwise.
  task automatic chk_wr();
    if (pend) begin
      chk("wr_en", wr_en, 1);
      chk("wr_addr", wr_addr, pend_addr);
      chk("wr_data", wr_data, pend_data);
      pend = 1'b0;
    end else begin
      chk("wr_idle", wr_en, 0);
    end
  endtask

  // Shift nbits out on mosi; miso is sampled before each rising edge.
  task automatic send_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int k = 0; k < nbits; k++) begin
      @(negedge sclk);
      bus.ss = 1'b0;
      #1;
      rx[k] = bus.miso;
      if (k == 0) chk_wr();
      bus.mosi = tx[k];
    end
  endtask

  task automatic end_frame();
    @(negedge sclk);
    chk_wr();
    bus.ss   = 1'b1;
    bus.mosi = 1'b0;
    @(negedge sclk);
    chk("wr_after", wr_en, 0);
    chk("frame_err", frame_err, exp_err);
  endtask

  // Full frame: command then n data bytes (d[0] first).
  task automatic frame(input logic [7:0] cmd, input int n, input logic [3:0][7:0] d);
    logic [7:0]        rx;
    logic [ADDR_W-1:0] a;
    a = cmd[ADDR_W-1:0];
    send_bits(cmd, 8, rx);
    chk("cmd_miso", rx, 0);
    for (int j = 0; j < n; j++) begin
      send_bits(d[j], 8, rx);
      if (cmd[7]) begin
        chk("rd_byte", rx, (int'(a) == NREG-1) ? status_in : mdl[a]);
      end else begin
        chk("wr_miso", rx, 0);
        if (int'(a) != NREG-1) mdl[a] = d[j];
        pend = 1'b1; pend_addr = a; pend_data = d[j];
      end
      a = a + 1'b1;
    end
    end_frame();
  endtask

  initial begin
    logic [7:0]       rx;
    logic [3:0][7:0]  d;
    bus.ss = 1'b1;
    bus.mosi = 1'b0;
    for (int i = 0; i < NREG; i++) mdl[i] = 8'h00;

    // Reset state, with ss low so miso is driven.
    repeat (2) @(negedge sclk);
    bus.ss = 1'b0;
    #1;
    chk("rst_miso", bus.miso, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_ferr", frame_err, 0);
    bus.ss = 1'b1;
    rst = 1'b1;

    // Single write then read back.
    frame(8'h02, 1, {24'h0, 8'hA5});
    frame(8'h82, 1, 32'h0);

    // Burst write across the read-only top address, then read back.
    frame(8'h06, 2, {16'h0, 8'h22, 8'h11});
    chk("reg6", mdl[6], 8'h11);
    status_in = 8'h99;
    frame(8'h86, 2, 32'h0);

    // Read burst wrapping from status to address 0.
    status_in = 8'h5C;
    frame(8'h87, 3, 32'h0);

    // Status change mid-byte must not alter the snapshot.
    status_in = 8'h3C;
    send_bits(8'h87, 8, rx);
    @(posedge sclk);
    #1 status_in = 8'hC3;
    send_bits(8'h00, 8, rx);
    chk("snapshot", rx, 8'h3C);
    end_frame();

    // Randomized frames.
    for (int i = 0; i < 25; i++) begin
      status_in = 8'($urandom);
      d = {$urandom};
      frame(8'($urandom), $urandom_range(1, 4), d);
    end

    // Deselect with miso driven high: must float, no error at byte boundary.
    frame(8'h03, 1, {24'h0, 8'hFF});
    send_bits(8'h83, 8, rx);
    @(negedge sclk);
    #1;
    chk("miso_b0", bus.miso, 1);
    bus.ss = 1'b1;
    #1;
    chk("miso_hiz", bus.miso !== 1'b1, 1);
    @(negedge sclk);
    chk("ferr_clean", frame_err, 0);

    // Partial data byte: dropped and flagged; next frame decodes normally.
    send_bits(8'h01, 8, rx);
    send_bits(8'h77, 3, rx);
    exp_err = 1'b1;
    end_frame();
    frame(8'h81, 1, 32'h0);
    frame(8'h05, 1, {24'h0, 8'h3E});
    frame(8'h85, 1, 32'h0);

    // Reset in the middle of a read byte.
    send_bits(8'h85, 8, rx);
    send_bits(8'h5A, 3, rx);
    @(negedge sclk);
    rst = 1'b0;
    @(negedge sclk);
    #1;
    chk("mid_miso", bus.miso, 0);
    chk("mid_wr_en", wr_en, 0);
    chk("mid_wr_addr", wr_addr, 0);
    chk("mid_wr_data", wr_data, 0);
    chk("mid_ferr", frame_err, 0);
    rst = 1'b1;
    bus.ss = 1'b1;
    exp_err = 1'b0;
    pend = 1'b0;
    for (int i = 0; i < NREG; i++) mdl[i] = 8'h00;
    @(negedge sclk);
    chk("post_ferr", frame_err, 0);
    status_in = 8'hE7;
    frame(8'h80, 4, 32'h0);
    frame(8'h84, 4, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
